// File: rtl/dm_timer_bridge.sv
// Data-memory responder: word RAM plus a CTRL/PRESET/COUNT countdown timer with a level irq.
// Reads are combinational on the address (zero latency); writes commit at posedge; no stall path.
module dm_timer_bridge #(
    parameter int          DM_WORDS   = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    localparam int          AW        = $clog2(DM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DM_WORDS) << 2;
    localparam logic [29:0] TW_CTRL   = TIMER_BASE[31:2];
    localparam logic [29:0] TW_PRESET = TIMER_BASE[31:2] + 30'd1;
    localparam logic [29:0] TW_COUNT  = TIMER_BASE[31:2] + 30'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_e;

    logic [31:0]   mem_q [DM_WORDS];
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          ram_we;
    logic          ctrl_sel;
    logic          preset_sel;
    logic          count_sel;
    logic          full_wr;
    logic          ctrl_wr;
    logic          preset_wr;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        int_flag_q, int_flag_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_d;

    // The M-stage PC only feeds the simulation trace.
    logic unused_inst;
    assign unused_inst = ^m_inst_addr;

    assign word_addr  = m_data_addr[31:2];
    assign ram_idx    = m_data_addr[AW+1:2];
    assign ram_hit    = m_data_addr < RAM_BYTES;
    assign ram_we     = ram_hit && (m_data_byteen != 4'b0000);
    assign ctrl_sel   = (word_addr == TW_CTRL);
    assign preset_sel = (word_addr == TW_PRESET);
    assign count_sel  = (word_addr == TW_COUNT);
    assign full_wr    = (m_data_byteen == 4'b1111);
    assign ctrl_wr    = full_wr && ctrl_sel;
    assign preset_wr  = full_wr && preset_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (m_data_byteen[b]) begin
                    mem_q[ram_idx][8*b +: 8] <= m_data_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (ram_hit) begin
            rdata_d = mem_q[ram_idx];
        end else if (ctrl_sel) begin
            rdata_d = {28'd0, ctrl_q};
        end else if (preset_sel) begin
            rdata_d = preset_q;
        end else if (count_sel) begin
            rdata_d = count_q;
        end
    end

    assign m_data_rdata = rdata_d;

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        int_flag_d = int_flag_q;
        irq_d      = int_flag_q & ctrl_q[3];

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'd0) begin
                    int_flag_d = 1'b1;
                    state_d    = ST_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                // MODE 1x behaves as one-shot.
                if (ctrl_q[2:1] == 2'b01) begin
                    int_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A CPU CTRL write overrides the whole FSM step and restarts from IDLE.
        if (ctrl_wr) begin
            ctrl_d     = m_data_wdata[3:0];
            int_flag_d = 1'b0;
            count_d    = count_q;
            state_d    = ST_IDLE;
        end
        if (preset_wr) begin
            preset_d = m_data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            int_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            int_flag_q <= int_flag_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule
